// File: rtl/mimo_frame_loader.sv
// mimo_frame_loader: serial operand loader and result capture for the 2x2 QR MIMO detector.
// Collects one H matrix and N_SYM y vectors per frame and holds them steady on the det_* outputs.
// After DET_LAT settle cycles it captures {demod_1, demod_2} and offers it on a valid/ready port.
// Optional feature macro: MIMO_H_HOLD_EN adds the h_hold input, so a frame can reuse the stored H.
module mimo_frame_loader #(
    parameter int unsigned W       = 28,
    parameter int unsigned N_SYM   = 4,
    parameter int unsigned DET_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_sof,
`ifdef MIMO_H_HOLD_EN
    input  logic                h_hold,
`endif
    output logic                in_ready,
    output logic signed [W-1:0] det_H11_real,
    output logic signed [W-1:0] det_H11_imag,
    output logic signed [W-1:0] det_H12_real,
    output logic signed [W-1:0] det_H12_imag,
    output logic signed [W-1:0] det_H21_real,
    output logic signed [W-1:0] det_H21_imag,
    output logic signed [W-1:0] det_H22_real,
    output logic signed [W-1:0] det_H22_imag,
    output logic signed [W-1:0] det_y_real_1,
    output logic signed [W-1:0] det_y_imag_1,
    output logic signed [W-1:0] det_y_real_2,
    output logic signed [W-1:0] det_y_imag_2,
    input  logic [2:0]          demod_1,
    input  logic [2:0]          demod_2,
    output logic [5:0]          out_sym,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                err_sof
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_H = 3'd1;
    localparam logic [2:0] LOAD_Y = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;

    logic [2:0]          state;
    logic [2:0]          widx;
    logic [7:0]          sym_idx;
    logic [3:0]          cnt;
    logic signed [W-1:0] h_reg [8];
    logic signed [W-1:0] y_reg [4];

    logic       accept;
    logic       hold;
    logic       h_we;
    logic       y_we;
    logic [2:0] h_addr;
    logic [1:0] y_addr;

`ifdef MIMO_H_HOLD_EN
    assign hold = h_hold;
`else
    assign hold = 1'b0;
`endif

    assign in_ready = (state == IDLE) || (state == LOAD_H) || (state == LOAD_Y);
    assign accept   = in_valid & in_ready;

    // Route each accepted word to its operand register; a sof word always restarts the frame.
    always_comb begin
        h_we   = 1'b0;
        y_we   = 1'b0;
        h_addr = widx;
        y_addr = widx[1:0];
        if (accept) begin
            if (in_sof) begin
                if (hold) begin
                    y_we   = 1'b1;
                    y_addr = 2'd0;
                end else begin
                    h_we   = 1'b1;
                    h_addr = 3'd0;
                end
            end else if (state == LOAD_H) begin
                h_we = 1'b1;
            end else if (state == LOAD_Y) begin
                y_we = 1'b1;
            end
        end
    end

    // Operand registers: written only by accepted words, never cleared between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) h_reg[i] <= '0;
            for (int i = 0; i < 4; i++) y_reg[i] <= '0;
        end else begin
            if (h_we) h_reg[h_addr] <= in_data;
            if (y_we) y_reg[y_addr] <= in_data;
        end
    end

    // Frame sequencing, settle timer and output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            widx      <= 3'd0;
            sym_idx   <= 8'd0;
            cnt       <= 4'd0;
            out_sym   <= 6'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err_sof   <= 1'b0;
        end else begin
            err_sof <= 1'b0;
            case (state)
                IDLE, LOAD_H, LOAD_Y: begin
                    if (accept) begin
                        if (in_sof) begin
                            // Any sof restarts; it is only an error when a frame was in flight.
                            err_sof <= (state != IDLE);
                            widx    <= 3'd1;
                            sym_idx <= 8'd0;
                            state   <= hold ? LOAD_Y : LOAD_H;
                        end else if (state == LOAD_H) begin
                            if (widx == 3'd7) begin
                                state   <= LOAD_Y;
                                widx    <= 3'd0;
                                sym_idx <= 8'd0;
                            end else begin
                                widx <= widx + 3'd1;
                            end
                        end else if (state == LOAD_Y) begin
                            if (widx == 3'd3) begin
                                state <= SETTLE;
                                cnt   <= 4'd0;
                            end else begin
                                widx <= widx + 3'd1;
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == 4'(DET_LAT - 1)) begin
                        out_sym   <= {demod_1, demod_2};
                        out_valid <= 1'b1;
                        out_last  <= (sym_idx == 8'(N_SYM - 1));
                        state     <= OUT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state <= IDLE;
                        end else begin
                            sym_idx <= sym_idx + 8'd1;
                            widx    <= 3'd0;
                            state   <= LOAD_Y;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign det_H11_real = h_reg[0];
    assign det_H11_imag = h_reg[1];
    assign det_H12_real = h_reg[2];
    assign det_H12_imag = h_reg[3];
    assign det_H21_real = h_reg[4];
    assign det_H21_imag = h_reg[5];
    assign det_H22_real = h_reg[6];
    assign det_H22_imag = h_reg[7];
    assign det_y_real_1 = y_reg[0];
    assign det_y_imag_1 = y_reg[1];
    assign det_y_real_2 = y_reg[2];
    assign det_y_imag_2 = y_reg[3];

endmodule

// File: tb/tb_mimo_frame_loader.sv
// Testbench for mimo_frame_loader: directed frame sequence with random operand words.
// The expected operands are simply the words the bench sent, in frame order.
// MIMO_H_HOLD_EN enables the H-reuse frame.
module tb_mimo_frame_loader;

    localparam int W       = 28;
    localparam int N_SYM   = 4;
    localparam int DET_LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          h_hold = 1'b0;
    logic          in_ready;
    logic [W-1:0]  det_H11_real, det_H11_imag, det_H12_real, det_H12_imag;
    logic [W-1:0]  det_H21_real, det_H21_imag, det_H22_real, det_H22_imag;
    logic [W-1:0]  det_y_real_1, det_y_imag_1, det_y_real_2, det_y_imag_2;
    logic [2:0]    demod_1 = '0;
    logic [2:0]    demod_2 = '0;
    logic [5:0]    out_sym;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          err_sof;

    int n_checks = 0;
    int n_err    = 0;

    // Reference: the operands the detector should currently see.
    logic [W-1:0] exp_h [8];
    logic [W-1:0] exp_y [4];

    always #5 clk = ~clk;

    mimo_frame_loader #(.W(W), .N_SYM(N_SYM), .DET_LAT(DET_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
`ifdef MIMO_H_HOLD_EN
        .h_hold       (h_hold),
`endif
        .in_ready     (in_ready),
        .det_H11_real (det_H11_real),
        .det_H11_imag (det_H11_imag),
        .det_H12_real (det_H12_real),
        .det_H12_imag (det_H12_imag),
        .det_H21_real (det_H21_real),
        .det_H21_imag (det_H21_imag),
        .det_H22_real (det_H22_real),
        .det_H22_imag (det_H22_imag),
        .det_y_real_1 (det_y_real_1),
        .det_y_imag_1 (det_y_imag_1),
        .det_y_real_2 (det_y_real_2),
        .det_y_imag_2 (det_y_imag_2),
        .demod_1      (demod_1),
        .demod_2      (demod_2),
        .out_sym      (out_sym),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .err_sof      (err_sof)
    );

    wire [8*W-1:0] det_h_vec = {det_H11_real, det_H11_imag, det_H12_real, det_H12_imag,
                                det_H21_real, det_H21_imag, det_H22_real, det_H22_imag};
    wire [4*W-1:0] det_y_vec = {det_y_real_1, det_y_imag_1, det_y_real_2, det_y_imag_2};

    function automatic logic [8*W-1:0] exp_h_vec();
        logic [8*W-1:0] v;
        for (int i = 0; i < 8; i++) v[(7-i)*W +: W] = exp_h[i];
        return v;
    endfunction

    function automatic logic [4*W-1:0] exp_y_vec();
        logic [4*W-1:0] v;
        for (int i = 0; i < 4; i++) v[(3-i)*W +: W] = exp_y[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one word from a negedge; returns 1 time unit after the edge that accepts it.
    task automatic send_word(input logic [W-1:0] d, input logic sof);
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_sof   = sof;
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("send_timeout", done, 1);
    endtask

    // Load a fresh H with sof on the first word.
    task automatic load_h();
        for (int i = 0; i < 8; i++) exp_h[i] = W'($urandom);
        for (int i = 0; i < 8; i++) send_word(exp_h[i], i == 0);
        check("det_H_load", det_h_vec, exp_h_vec());
    endtask

    // Wait for a symbol, optionally stall the consumer, then complete the handshake.
    task automatic recv(input logic [5:0] exp_sym, input logic exp_last, input int stall);
        int n = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
        end
        check("valid_seen", seen, 1);
        // Edge accepting y2i is followed by DET_LAT edges; the first negedge counts as 1.
        check("valid_latency", n, DET_LAT + 1);
        check("out_sym", out_sym, exp_sym);
        check("out_last", out_last, exp_last);
        check("in_ready_out", in_ready, 0);
        if (stall > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = W'($urandom);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_valid", out_valid, 1);
                check("stall_sym", out_sym, exp_sym);
                check("stall_last", out_last, exp_last);
                check("stall_in_ready", in_ready, 0);
                check("stall_det_y", det_y_vec, exp_y_vec());
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("valid_drop", out_valid, 0);
        check("in_ready_after", in_ready, 1);
    endtask

    task automatic run_sym(input logic [2:0] d1, input logic [2:0] d2, input logic last,
                           input int stall, input logic sof_first);
        for (int i = 0; i < 4; i++) exp_y[i] = W'($urandom);
        demod_1 = d1;
        demod_2 = d2;
        for (int i = 0; i < 4; i++) send_word(exp_y[i], sof_first && (i == 0));
        check("det_y_load", det_y_vec, exp_y_vec());
        recv({d1, d2}, last, stall);
    endtask

    initial begin
        logic [W-1:0] w;
        for (int i = 0; i < 8; i++) exp_h[i] = '0;
        for (int i = 0; i < 4; i++) exp_y[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_sym", out_sym, 0);
        check("rst_err_sof", err_sof, 0);
        check("rst_det", {det_h_vec, det_y_vec}, 0);
        rst = 1'b0;

        // Words without sof in IDLE are discarded
        for (int i = 0; i < 3; i++) send_word(W'($urandom), 1'b0);
        check("idle_discard_det", {det_h_vec, det_y_vec}, 0);
        check("idle_in_ready", in_ready, 1);

        // Frame 1: fixed decisions 5/2, stall after the first symbol
        load_h();
        for (int s = 0; s < N_SYM; s++) begin
            run_sym(3'd5, 3'd2, s == N_SYM - 1, (s == 0) ? 10 : 0, 1'b0);
            check("f1_det_H_stable", det_h_vec, exp_h_vec());
        end
        // Back in IDLE: a non-sof word must not touch any operand
        send_word(W'($urandom), 1'b0);
        check("post_frame_discard", {det_h_vec, det_y_vec}, {exp_h_vec(), exp_y_vec()});

        // Frame 2: premature sof on the third y word of the first symbol
        load_h();
        exp_y[0] = W'($urandom);
        exp_y[1] = W'($urandom);
        send_word(exp_y[0], 1'b0);
        send_word(exp_y[1], 1'b0);
        w = W'($urandom);
        send_word(w, 1'b1);
        check("abort_err_sof", err_sof, 1);
        check("abort_H11r", det_H11_real, w);
        check("abort_no_valid", out_valid, 0);
        exp_h[0] = w;
        for (int i = 1; i < 8; i++) begin
            exp_h[i] = W'($urandom);
            send_word(exp_h[i], 1'b0);
            if (i == 1) check("abort_err_pulse", err_sof, 0);
        end
        check("abort_det_H", det_h_vec, exp_h_vec());
        for (int s = 0; s < N_SYM; s++)
            run_sym(3'($urandom), 3'($urandom), s == N_SYM - 1, 0, 1'b0);

        // Frame 3: reset while settling
        load_h();
        for (int i = 0; i < 4; i++) begin
            exp_y[i] = W'($urandom);
            send_word(exp_y[i], 1'b0);
        end
        @(negedge clk);
        check("settle_no_valid", out_valid, 0);
        check("settle_in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_det", {det_h_vec, det_y_vec}, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) exp_h[i] = '0;
        for (int i = 0; i < 4; i++) exp_y[i] = '0;

`ifdef MIMO_H_HOLD_EN
        // Full frame, then a frame reusing H via h_hold
        load_h();
        for (int s = 0; s < N_SYM; s++)
            run_sym(3'($urandom), 3'($urandom), s == N_SYM - 1, 0, 1'b0);
        h_hold = 1'b1;
        for (int s = 0; s < N_SYM; s++) begin
            run_sym(3'($urandom), 3'($urandom), s == N_SYM - 1, 0, s == 0);
            h_hold = 1'b0;
            check("hold_det_H", det_h_vec, exp_h_vec());
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mimo_frame_loader.md
# mimo_frame_loader

Sequential front-end for the 2x2 QR MIMO detector. It accepts a serial word stream (one channel matrix H per frame, then N_SYM received vectors y), holds all twelve detector operands in registers, and waits a fixed settle time for the combinational QR / back-substitution / de_mod path. It then captures the two 3-bit demodulated symbols and presents them downstream with a valid/ready handshake.

## Interface
Parameters:
- W, 28, operand word width; matches the detector's signed inputs.
- N_SYM, 4, received vectors per frame sharing one H (1..255).
- DET_LAT, 2, settle cycles allowed for the detector path (1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  W  signed operand word.
- in_valid  input  1  in_data is valid.
- in_sof  input  1  qualifies the first word of a frame; sampled only on accepted words.
- in_ready  output  1  loader can accept a word.
- det_H11_real … det_H22_imag  output  W each (8 ports)  registered H operands to the detector.
- det_y_real_1, det_y_imag_1, det_y_real_2, det_y_imag_2  output  W each  registered y operands.
- demod_1, demod_2  input  3 each  detector symbol decisions.
- out_sym  output  6  {demod_1, demod_2} captured.
- out_valid  output  1  out_sym is valid.
- out_ready  input  1  downstream accepts out_sym.
- out_last  output  1  out_sym is the final symbol of the frame; valid with out_valid.
- err_sof  output  1  one-cycle pulse when a frame is aborted by a premature in_sof.

## Operation
- Word accepted = in_valid & in_ready at a rising edge.
- Frame word order: H11r, H11i, H12r, H12i, H21r, H21i, H22r, H22i. Then N_SYM groups of y1r, y1i, y2r, y2i.
- FSM states:
  - IDLE: in_ready=1. A word accepted with in_sof=1 is stored as H11r and the FSM moves to LOAD_H with widx=1. Words accepted without sof are discarded.
  - LOAD_H: in_ready=1. Each accepted word goes to H register widx. After widx=7, go to LOAD_Y with widx=0, sym_idx=0.
  - LOAD_Y: in_ready=1. Each accepted word goes to y register widx. After widx=3, go to SETTLE with cnt=0.
  - SETTLE: in_ready=0. cnt increments each cycle. At cnt=DET_LAT-1 the edge captures {demod_1, demod_2} into out_sym, sets out_valid=1 and out_last=(sym_idx==N_SYM-1), and moves to OUT.
  - OUT: in_ready=0. On out_valid & out_ready: out_valid=0, out_last=0. Then if out_last, go to IDLE; else sym_idx+1 and go to LOAD_Y with widx=0.
- Premature sof: in LOAD_H or LOAD_Y, an accepted word with in_sof=1 aborts the current frame. err_sof pulses, the word is stored as H11r, and the FSM goes to LOAD_H with widx=1. Already-emitted symbols are unaffected.
- Operand registers are updated only by accepted words. They are never cleared at frame boundaries, so the detector sees stable inputs throughout SETTLE and OUT.
- No arithmetic is performed on operands. Words pass through bit-exact, signed W bits.

## Timing
- Reset values: in_ready=1 (state IDLE), every det_* output=0, out_sym=0, out_valid=0, out_last=0, err_sof=0, and all counters=0.
- Reset asserted mid-frame returns to IDLE immediately. Any pending out_valid drops.
- Latency: out_valid rises DET_LAT cycles after the edge that accepts y2i.
- out_sym and out_last are held stable while out_valid=1 and out_ready=0.
- Throughput with out_ready held at 1: one symbol per 4+DET_LAT+1 cycles.
- in_ready returns to 1 in the cycle after the out handshake edge. There is no bubble beyond that.

## Configuration
- MIMO_H_HOLD_EN
  - When defined, an extra input h_hold (1 bit) exists. An accepted sof word with h_hold=1 is stored as y1r, the H registers are kept, and the FSM goes directly to LOAD_Y with widx=1, sym_idx=0. This reuses the previous H.
  - When not defined, the port is absent and every frame loads H.

## Test plan
- Reset, then one frame (N_SYM=4, DET_LAT=2), in_valid held at 1, out_ready=1, demod_1=3'd5, demod_2=3'd2 → H and y registers equal the sent words. Four out_sym=6'b101010 pulses, each 2 cycles after its y2i. out_last is set on the 4th only, and the FSM returns to IDLE.
- out_ready=0 for 10 cycles after the first symbol → out_valid and out_sym stay constant, in_ready=0, and no words are consumed. Releasing out_ready resumes LOAD_Y.
- Three words without sof in IDLE → all accepted and discarded. Every det_* output remains 0.
- in_sof on the 3rd y word of symbol 1 → err_sof pulses once, that word appears on det_H11_real, and the next 7 words load H.
- rst asserted during SETTLE → out_valid stays 0, in_ready=1 next cycle, and all det_* outputs=0.
- With MIMO_H_HOLD_EN: second frame with h_hold=1 and 16 y words → the H registers are unchanged and 4 symbols are emitted.
